pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_pkg.sv | 70 +++++++
 rtl/load_use_detect.sv | 22 ++
 rtl/pipe_hazard_ctrl.sv | 142 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding,
// the stage-control bundle and the canned control patterns built from it.
package pipe_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_flush;
    logic ex_mem_en;
    logic ex_mem_flush;
    logic mem_wb_en;
    logic mem_wb_flush;
  } stage_ctrl_t;

  localparam int CTRL_W = $bits(stage_ctrl_t);

  // Every stage advances, nothing squashed.
  function automatic stage_ctrl_t ctrl_pass();
    stage_ctrl_t c;
    c           = '0;
    c.pc_en     = 1'b1;
    c.if_id_en  = 1'b1;
    c.id_ex_en  = 1'b1;
    c.ex_mem_en = 1'b1;
    c.mem_wb_en = 1'b1;
    return c;
  endfunction

  function automatic stage_ctrl_t ctrl_branch();
    stage_ctrl_t c;
    c             = ctrl_pass();
    c.if_id_flush = 1'b1;
    c.id_ex_flush = 1'b1;
    return c;
  endfunction

  // Hold PC and IF/ID, inject one bubble into EX.
  function automatic stage_ctrl_t ctrl_bubble();
    stage_ctrl_t c;
    c             = ctrl_pass();
    c.pc_en       = 1'b0;
    c.if_id_en    = 1'b0;
    c.id_ex_flush = 1'b1;
    return c;
  endfunction

  // Front of the pipe frozen behind MEM; WB keeps moving but receives a bubble.
  function automatic stage_ctrl_t ctrl_mem_stall();
    stage_ctrl_t c;
    c              = '0;
    c.mem_wb_en    = 1'b1;
    c.mem_wb_flush = 1'b1;
    return c;
  endfunction

  function automatic stage_ctrl_t ctrl_halt();
    return '0;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard comparator: the load in EX writes a register that the
// instruction in ID reads. x0 never creates a dependency.
module load_use_detect
  import pipe_pkg::*;
(
  input  logic             id_ex_memread,
  input  logic [REG_W-1:0] id_ex_rd,
  input  logic [REG_W-1:0] if_id_rs1,
  input  logic [REG_W-1:0] if_id_rs2,
  output logic             hazard
);

  logic rd_nonzero;
  logic rs1_match;
  logic rs2_match;

  assign rd_nonzero = (id_ex_rd != '0);
  assign rs1_match  = (id_ex_rd == if_id_rs1);
  assign rs2_match  = (id_ex_rd == if_id_rs2);
  assign hazard     = id_ex_memread && rd_nonzero && (rs1_match || rs2_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline hazard controller: memory stall / branch flush / load-use
// bubble arbitration with a memory timeout. Define PIPE_PERF_CNT_EN to add
// the stall_cnt / flush_cnt performance counters.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_ex_memread,
  input  logic [REG_W-1:0] id_ex_rd,
  input  logic [REG_W-1:0] if_id_rs1,
  input  logic [REG_W-1:0] if_id_rs2,
  input  logic             branch_taken_ex,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             ex_mem_flush,
  output logic             mem_wb_en,
  output logic             mem_wb_flush,
  output logic             mem_timeout
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      flush_cnt
`endif
);

  localparam int                 CNT_W     = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]   WAIT_TERM = CNT_W'(TIMEOUT_CYCLES - 1);

  hz_state_e        state;
  hz_state_e        state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_cnt_nxt;
  logic             timeout_q;
  logic             hazard;
  logic             mem_stall;
  stage_ctrl_t      ctrl;

  load_use_detect u_load_use_detect (
    .id_ex_memread (id_ex_memread),
    .id_ex_rd      (id_ex_rd),
    .if_id_rs1     (if_id_rs1),
    .if_id_rs2     (if_id_rs2),
    .hazard        (hazard)
  );

  // A request completing in the same cycle is a zero-wait access, not a stall.
  assign mem_stall = mem_req && !mem_ready;

  always_comb begin
    ctrl         = ctrl_pass();
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      RUN: begin
        if (mem_stall) begin
          ctrl         = ctrl_mem_stall();
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = '0;
        end else if (branch_taken_ex) begin
          ctrl = ctrl_branch();
        end else if (hazard) begin
          ctrl = ctrl_bubble();
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          ctrl      = branch_taken_ex ? ctrl_branch() : ctrl_pass();
          state_nxt = RUN;
        end else if (wait_cnt == WAIT_TERM) begin
          ctrl      = ctrl_mem_stall();
          state_nxt = ERR;
        end else begin
          ctrl         = ctrl_mem_stall();
          wait_cnt_nxt = wait_cnt + CNT_W'(1);
        end
      end
      ERR: begin
        ctrl = ctrl_halt();
      end
      default: begin
        ctrl      = ctrl_halt();
        state_nxt = RUN;
      end
    endcase
    // Reset must silence the stage controls immediately, not at the next edge.
    if (!rst_n) begin
      ctrl = ctrl_halt();
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (state == MEM_WAIT && state_nxt == ERR) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign pc_en        = ctrl.pc_en;
  assign if_id_en     = ctrl.if_id_en;
  assign if_id_flush  = ctrl.if_id_flush;
  assign id_ex_en     = ctrl.id_ex_en;
  assign id_ex_flush  = ctrl.id_ex_flush;
  assign ex_mem_en    = ctrl.ex_mem_en;
  assign ex_mem_flush = ctrl.ex_mem_flush;
  assign mem_wb_en    = ctrl.mem_wb_en;
  assign mem_wb_flush = ctrl.mem_wb_flush;
  assign mem_timeout  = timeout_q;

`ifdef PIPE_PERF_CNT_EN
  // if_id_flush is only ever raised by a taken branch, so it marks flush events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (state != ERR) begin
      if (!ctrl.pc_en && stall_cnt != 32'hFFFF_FFFF) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (ctrl.if_id_flush && flush_cnt != 32'hFFFF_FFFF) begin
        flush_cnt <= flush_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: vector table, directed multi-cycle sequences
// and randomized traffic against a behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int TO = 64;

  // Observation word: {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
  //                    ex_mem_en, ex_mem_flush, mem_wb_en, mem_wb_flush, mem_timeout}
  localparam logic [31:0] E_PASS   = 32'b11_0101_0100;
  localparam logic [31:0] E_BRANCH = 32'b11_1111_0100;
  localparam logic [31:0] E_BUBBLE = 32'b00_0111_0100;
  localparam logic [31:0] E_STALL  = 32'b00_0000_0110;
  localparam logic [31:0] E_ERR    = 32'b00_0000_0001;

  localparam int M_RUN  = 0;
  localparam int M_WAIT = 1;
  localparam int M_ERR  = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_ex_memread;
  logic [4:0] id_ex_rd, if_id_rs1, if_id_rs2;
  logic       branch_taken_ex, mem_req, mem_ready;
  logic       pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
  logic       ex_mem_en, ex_mem_flush, mem_wb_en, mem_wb_flush, mem_timeout;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int m_mode   = M_RUN;
  int m_waited = 0;

  typedef struct packed {
    logic        mr;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        br;
    logic        req;
    logic        rdy;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [11];

  pipe_hazard_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_ex_memread   (id_ex_memread),
    .id_ex_rd        (id_ex_rd),
    .if_id_rs1       (if_id_rs1),
    .if_id_rs2       (if_id_rs2),
    .branch_taken_ex (branch_taken_ex),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .pc_en           (pc_en),
    .if_id_en        (if_id_en),
    .if_id_flush     (if_id_flush),
    .id_ex_en        (id_ex_en),
    .id_ex_flush     (id_ex_flush),
    .ex_mem_en       (ex_mem_en),
    .ex_mem_flush    (ex_mem_flush),
    .mem_wb_en       (mem_wb_en),
    .mem_wb_flush    (mem_wb_flush),
    .mem_timeout     (mem_timeout)
`ifdef PIPE_PERF_CNT_EN
    ,
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] obs();
    return {22'd0, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
            ex_mem_en, ex_mem_flush, mem_wb_en, mem_wb_flush, mem_timeout};
  endfunction

  // Reference behaviour: pick the winning event by priority, then track how
  // many cycles the pipe has been waiting on memory.
  function automatic logic [31:0] model_exp();
    logic dep;
    if (!rst_n) return 32'd0;
    dep = id_ex_memread && (id_ex_rd != 5'd0) &&
          (id_ex_rd == if_id_rs1 || id_ex_rd == if_id_rs2);
    if (m_mode == M_ERR) return E_ERR;
    if (m_mode == M_WAIT) begin
      if (!mem_ready) return E_STALL;
      return branch_taken_ex ? E_BRANCH : E_PASS;
    end
    if (mem_req && !mem_ready) return E_STALL;
    if (branch_taken_ex) return E_BRANCH;
    if (dep) return E_BUBBLE;
    return E_PASS;
  endfunction

  task automatic model_adv();
    if (!rst_n) begin
      m_mode   = M_RUN;
      m_waited = 0;
    end else if (m_mode == M_RUN) begin
      if (mem_req && !mem_ready) begin
        m_mode   = M_WAIT;
        m_waited = 0;
      end
    end else if (m_mode == M_WAIT) begin
      if (mem_ready) begin
        m_mode = M_RUN;
      end else begin
        m_waited++;
        if (m_waited >= TO) m_mode = M_ERR;
      end
    end
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic drive(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic br, input logic req,
                       input logic rdy);
    id_ex_memread   = mr;
    id_ex_rd        = rd;
    if_id_rs1       = rs1;
    if_id_rs2       = rs2;
    branch_taken_ex = br;
    mem_req         = req;
    mem_ready       = rdy;
  endtask

  task automatic step_exp(input string nm, input logic [31:0] exp);
    #2 check(nm, obs(), exp);
    model_adv();
    @(negedge clk);
  endtask

  task automatic do_reset(input string nm);
    #1 rst_n = 1'b0;
    #1 check(nm, obs(), 32'd0);
    model_adv();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int stalls;
    int got_err;
    logic seg_dead;

    rst_n = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    #2 check("reset_state", obs(), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef PIPE_PERF_CNT_EN
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    step_exp("perf_stall0", E_STALL);
    step_exp("perf_stall1", E_STALL);
    step_exp("perf_stall2", E_STALL);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
    step_exp("perf_ready", E_PASS);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    step_exp("perf_br0", E_BRANCH);
    step_exp("perf_br1", E_BRANCH);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    step_exp("perf_idle", E_PASS);
    check("stall_cnt", stall_cnt, 32'd3);
    check("flush_cnt", flush_cnt, 32'd2);
`endif

    // Single-cycle RUN vectors: none of them leaves RUN.
    tbl[0]  = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, E_PASS};
    tbl[1]  = '{1'b1, 5'd5,  5'd1,  5'd5,  1'b0, 1'b0, 1'b0, E_BUBBLE};
    tbl[2]  = '{1'b1, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, E_PASS};
    tbl[3]  = '{1'b1, 5'd5,  5'd5,  5'd2,  1'b0, 1'b0, 1'b0, E_BUBBLE};
    tbl[4]  = '{1'b0, 5'd5,  5'd5,  5'd5,  1'b0, 1'b0, 1'b0, E_PASS};
    tbl[5]  = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b1, 1'b0, 1'b0, E_BRANCH};
    tbl[6]  = '{1'b1, 5'd5,  5'd3,  5'd5,  1'b1, 1'b0, 1'b0, E_BRANCH};
    tbl[7]  = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b1, 1'b1, E_PASS};
    tbl[8]  = '{1'b1, 5'd31, 5'd31, 5'd31, 1'b0, 1'b0, 1'b0, E_BUBBLE};
    tbl[9]  = '{1'b1, 5'd7,  5'd6,  5'd8,  1'b0, 1'b0, 1'b0, E_PASS};
    tbl[10] = '{1'b1, 5'd5,  5'd0,  5'd5,  1'b0, 1'b1, 1'b1, E_BUBBLE};
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].mr, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].br, tbl[i].req, tbl[i].rdy);
      step_exp($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Memory stall, ready arrives after three frozen cycles.
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    step_exp("wait3_c0", E_STALL);
    step_exp("wait3_c1", E_STALL);
    step_exp("wait3_c2", E_STALL);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
    step_exp("wait3_ready", E_PASS);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    step_exp("wait3_run", E_PASS);

    // Stall beats branch; branch flush only lands if still asserted at ready.
    drive(1'b1, 5'd4, 5'd4, 5'd0, 1'b1, 1'b1, 1'b0);
    step_exp("stall_br_c0", E_STALL);
    step_exp("stall_br_c1", E_STALL);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1);
    step_exp("stall_br_ready", E_BRANCH);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
    step_exp("stall_nobr_c0", E_STALL);
    step_exp("stall_nobr_c1", E_STALL);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
    step_exp("stall_nobr_ready", E_PASS);

    // Reset in the middle of a memory wait aborts it at once.
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    step_exp("abort_c0", E_STALL);
    step_exp("abort_c1", E_STALL);
    do_reset("abort_reset");
    drive(1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0);
    step_exp("abort_resume", E_BUBBLE);

    // Timeout: one RUN request cycle plus TO waited cycles, then ERR.
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    stalls  = 0;
    got_err = 0;
    for (int k = 0; k < 200 && got_err == 0; k++) begin
      #2;
      if (obs() == E_ERR) got_err = 1;
      else if (obs() == E_STALL) stalls++;
      model_adv();
      @(negedge clk);
    end
    check("timeout_reached", 32'(got_err), 32'd1);
    check("timeout_latency", 32'(stalls), 32'(TO + 1));
    drive(1'b1, 5'd3, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1);
    step_exp("err_hold0", E_ERR);
    step_exp("err_hold1", E_ERR);
    do_reset("err_reset");
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    step_exp("err_resume", E_PASS);

    // Randomized traffic; every third segment starves memory to reach ERR.
    for (int i = 0; i < 3000; i++) begin
      if (i % 300 == 0) do_reset("rand_reset");
      seg_dead = ((i / 300) % 3 == 2);
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 2) == 0),
            seg_dead ? 1'($urandom_range(0, 99) == 0) : 1'($urandom_range(0, 1)));
      #2 check($sformatf("rand%0d", i), obs(), model_exp());
      model_adv();
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
